// File: rtl/credit_bet_ctrl.sv
// Credit/bet controller: debits a bet, requests a spin, then adds the saturating payout.
// Optional macro BET_AUTO_CLAMP_EN: an unaffordable bet goes all-in instead of being refused.
module credit_bet_ctrl #(
   parameter int unsigned SCORE_W      = 17,
   parameter int unsigned BET_W        = 4,
   parameter int unsigned MAX_BET      = 5,
   parameter int unsigned START_CREDIT = 10
) (
   input  logic               CLOCK_50,
   input  logic               Reset,
   input  logic               max_sel,
   input  logic               bet_go,
   input  logic               spin_ack,
   input  logic               result_valid,
   input  logic [SCORE_W-1:0] payout,
   output logic [SCORE_W-1:0] credit,
   output logic [BET_W-1:0]   bet_amt,
   output logic               spin_req,
   output logic               busy,
   output logic               reject
);

   localparam logic [BET_W-1:0]   MAX_AMT    = BET_W'(MAX_BET);
   localparam logic [BET_W-1:0]   ONE_AMT    = BET_W'(1);
   localparam logic [SCORE_W-1:0] RST_CREDIT = SCORE_W'(START_CREDIT);

   typedef enum logic [1:0] {
      IDLE,
      DEBIT,
      SPIN_REQ,
      WAIT_RESULT
   } state_e;

   state_e             state_q, state_d;
   logic [SCORE_W-1:0] credit_q, credit_d;
   logic [BET_W-1:0]   bet_amt_q, bet_amt_d;
   logic               spin_req_q, spin_req_d;
   logic               busy_q, busy_d;
   logic               reject_q, reject_d;

   logic [BET_W-1:0]   req_amt;
   logic               can_afford;
   logic [SCORE_W-1:0] debit_val;
   logic [SCORE_W:0]   sum_ext;
   logic [SCORE_W-1:0] sat_sum;

   // Datapath: requested amount, affordability, debit and saturating credit-plus-payout.
   always_comb begin
      req_amt    = max_sel ? MAX_AMT : ONE_AMT;
      can_afford = (credit_q >= SCORE_W'(req_amt));
      debit_val  = credit_q - SCORE_W'(bet_amt_q);
      sum_ext    = {1'b0, credit_q} + {1'b0, payout};
      sat_sum    = sum_ext[SCORE_W] ? '1 : sum_ext[SCORE_W-1:0];
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      credit_d  = credit_q;
      bet_amt_d = bet_amt_q;
      reject_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bet_go) begin
               if (can_afford) begin
                  bet_amt_d = req_amt;
                  state_d   = DEBIT;
               end
`ifdef BET_AUTO_CLAMP_EN
               // Here credit < req <= MAX_BET, so credit fits in the bet width.
               else if (credit_q != '0) begin
                  bet_amt_d = BET_W'(credit_q);
                  state_d   = DEBIT;
               end
`endif
               else begin
                  reject_d = 1'b1;
               end
            end
         end
         DEBIT: begin
            credit_d = debit_val;
            state_d  = SPIN_REQ;
         end
         SPIN_REQ: begin
            if (spin_ack) begin
               state_d = WAIT_RESULT;
            end
         end
         WAIT_RESULT: begin
            if (result_valid) begin
               credit_d = sat_sum;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      spin_req_d = (state_d == SPIN_REQ);
      busy_d     = (state_d != IDLE);
   end

   // State and output registers; Reset overrides any operation in progress.
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state_q    <= IDLE;
         credit_q   <= RST_CREDIT;
         bet_amt_q  <= '0;
         spin_req_q <= 1'b0;
         busy_q     <= 1'b0;
         reject_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         bet_amt_q  <= bet_amt_d;
         spin_req_q <= spin_req_d;
         busy_q     <= busy_d;
         reject_q   <= reject_d;
      end
   end

   assign credit   = credit_q;
   assign bet_amt  = bet_amt_q;
   assign spin_req = spin_req_q;
   assign busy     = busy_q;
   assign reject   = reject_q;

endmodule

// File: tb/tb_credit_bet_ctrl.sv
// Directed self-checking bench for credit_bet_ctrl (default parameters).
// Define BET_AUTO_CLAMP_EN for both RTL and bench to exercise the all-in variant.
module tb_credit_bet_ctrl;

   localparam int unsigned SCORE_W = 17;
   localparam int unsigned BET_W   = 4;
   localparam logic [SCORE_W-1:0] MAXV = '1;

   logic               clk;
   logic               rst;
   logic               max_sel;
   logic               bet_go;
   logic               spin_ack;
   logic               result_valid;
   logic [SCORE_W-1:0] payout;
   logic [SCORE_W-1:0] credit;
   logic [BET_W-1:0]   bet_amt;
   logic               spin_req;
   logic               busy;
   logic               reject;

   int n_checks = 0;
   int n_fail   = 0;
   logic [SCORE_W-1:0] exp_credit;

   credit_bet_ctrl dut (
      .CLOCK_50    (clk),
      .Reset       (rst),
      .max_sel     (max_sel),
      .bet_go      (bet_go),
      .spin_ack    (spin_ack),
      .result_valid(result_valid),
      .payout      (payout),
      .credit      (credit),
      .bet_amt     (bet_amt),
      .spin_req    (spin_req),
      .busy        (busy),
      .reject      (reject)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_credit = SCORE_W'(10);
   endtask

   // Full accepted transaction; bet_go and result_valid are pulsed while waiting
   // for the ack to show they are ignored there.
   task automatic bet_cycle(input logic msel, input logic [SCORE_W-1:0] pay, input int ack_delay);
      logic [SCORE_W:0]   sum;
      logic [SCORE_W-1:0] amt;
      amt = msel ? SCORE_W'(5) : SCORE_W'(1);
      @(negedge clk);
      bet_go = 1'b1; max_sel = msel;
      @(negedge clk);
      bet_go = 1'b0;
      check("debit_busy", 32'(busy), 32'd1);
      check("debit_spin_req", 32'(spin_req), 32'd0);
      check("debit_bet_amt", 32'(bet_amt), 32'(amt));
      check("debit_credit_pre", 32'(credit), 32'(exp_credit));
      @(negedge clk);
      exp_credit = exp_credit - amt;
      check("spin_req_latency", 32'(spin_req), 32'd1);
      check("credit_after_debit", 32'(credit), 32'(exp_credit));
      for (int i = 0; i < ack_delay; i++) begin
         bet_go = 1'b1; max_sel = ~msel;
         result_valid = 1'b1; payout = SCORE_W'(777);
         @(negedge clk);
         check("spin_req_held", 32'(spin_req), 32'd1);
         check("credit_ignores_result", 32'(credit), 32'(exp_credit));
      end
      bet_go = 1'b0; result_valid = 1'b0;
      spin_ack = 1'b1;
      @(negedge clk);
      spin_ack = 1'b0;
      check("wait_spin_req_low", 32'(spin_req), 32'd0);
      check("wait_busy", 32'(busy), 32'd1);
      bet_go = 1'b1; max_sel = msel;
      @(negedge clk);
      bet_go = 1'b0;
      check("busy_bet_go_ignored", 32'(bet_amt), 32'(amt));
      check("busy_no_reject", 32'(reject), 32'd0);
      result_valid = 1'b1; payout = pay;
      @(negedge clk);
      result_valid = 1'b0;
      sum = {1'b0, exp_credit} + {1'b0, pay};
      exp_credit = sum[SCORE_W] ? MAXV : sum[SCORE_W-1:0];
      check("credit_after_payout", 32'(credit), 32'(exp_credit));
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic reject_step(input logic msel, input logic [BET_W-1:0] held_amt);
      @(negedge clk);
      bet_go = 1'b1; max_sel = msel;
      @(negedge clk);
      bet_go = 1'b0;
      check("reject_pulse", 32'(reject), 32'd1);
      check("reject_credit", 32'(credit), 32'(exp_credit));
      check("reject_busy", 32'(busy), 32'd0);
      check("reject_bet_amt", 32'(bet_amt), 32'(held_amt));
      @(negedge clk);
      check("reject_one_cycle", 32'(reject), 32'd0);
   endtask

   initial begin
      rst = 1'b1; max_sel = 1'b0; bet_go = 1'b0; spin_ack = 1'b0;
      result_valid = 1'b0; payout = '0; exp_credit = SCORE_W'(10);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_credit", 32'(credit), 32'd10);
      check("rst_bet_amt", 32'(bet_amt), 32'd0);
      check("rst_spin_req", 32'(spin_req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_reject", 32'(reject), 32'd0);

      // Max bet from 10, zero payout: 10 -> 5 -> 5.
      bet_cycle(1'b1, SCORE_W'(0), 0);
      check("max_bet_credit", 32'(credit), 32'd5);

      // Single bet, ack after 3 cycles, payout 20: 10 -> 9 -> 29.
      do_reset();
      bet_cycle(1'b0, SCORE_W'(20), 3);
      check("single_bet_credit", 32'(credit), 32'd29);

      // Bring credit down to 3.
      do_reset();
      bet_cycle(1'b1, SCORE_W'(0), 0);
      bet_cycle(1'b0, SCORE_W'(0), 0);
      bet_cycle(1'b0, SCORE_W'(0), 1);
      check("credit_is_3", 32'(credit), 32'd3);

`ifdef BET_AUTO_CLAMP_EN
      @(negedge clk);
      bet_go = 1'b1; max_sel = 1'b1;
      @(negedge clk);
      bet_go = 1'b0;
      check("clamp_no_reject", 32'(reject), 32'd0);
      check("clamp_bet_amt", 32'(bet_amt), 32'd3);
      check("clamp_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("clamp_credit", 32'(credit), 32'd0);
      check("clamp_spin_req", 32'(spin_req), 32'd1);
      spin_ack = 1'b1;
      @(negedge clk);
      spin_ack = 1'b0;
      result_valid = 1'b1; payout = '0;
      @(negedge clk);
      result_valid = 1'b0;
      exp_credit = '0;
      check("clamp_final_credit", 32'(credit), 32'd0);
      reject_step(1'b0, BET_W'(3));
`else
      reject_step(1'b1, BET_W'(1));
      bet_cycle(1'b0, SCORE_W'(0), 0);
      bet_cycle(1'b0, SCORE_W'(0), 0);
      // credit equals the request: still accepted, ends at 0.
      bet_cycle(1'b0, SCORE_W'(0), 0);
      check("exact_credit_zero", 32'(credit), 32'd0);
      reject_step(1'b0, BET_W'(1));
`endif

      // Saturation: reach 2^17-3, then win 10, then hit max exactly.
      do_reset();
      bet_cycle(1'b0, SCORE_W'(131060), 0);
      check("credit_near_max", 32'(credit), 32'd131069);
      bet_cycle(1'b0, SCORE_W'(10), 1);
      check("credit_saturated", 32'(credit), 32'd131071);
      bet_cycle(1'b0, SCORE_W'(1), 0);
      check("credit_exact_max", 32'(credit), 32'd131071);

      // Reset while waiting for the result.
      @(negedge clk);
      bet_go = 1'b1; max_sel = 1'b1;
      @(negedge clk);
      bet_go = 1'b0;
      @(negedge clk);
      spin_ack = 1'b1;
      @(negedge clk);
      spin_ack = 1'b0;
      check("pre_reset_wait_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_credit", 32'(credit), 32'd10);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_spin_req", 32'(spin_req), 32'd0);
      check("midrst_bet_amt", 32'(bet_amt), 32'd0);
      result_valid = 1'b1; payout = SCORE_W'(50);
      @(negedge clk);
      result_valid = 1'b0;
      check("idle_result_ignored", 32'(credit), 32'd10);
      check("idle_stays", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/credit_bet_ctrl.md
CREDIT_BET_CTRL -- requirements
Module: credit_bet_ctrl

Interface
REQ-001 Parameter SCORE_W, default 17: width of the credit register and payout path.
REQ-002 Parameter BET_W, default 4: width of the bet amount.
REQ-003 Parameter MAX_BET, default 5: debit when max bet is selected; must fit in BET_W bits and be at least 1.
REQ-004 Parameter START_CREDIT, default 10: credit value loaded at reset.
REQ-005 Port CLOCK_50, input, 1 bit: single clock; all logic rising-edge.
REQ-006 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port max_sel, input, 1 bit: 1 = max bet (MAX_BET), 0 = single bet (1); sampled on the bet_go cycle.
REQ-008 Port bet_go, input, 1 bit: one-cycle pulse that requests a bet.
REQ-009 Port spin_ack, input, 1 bit: spin engine accepts spin_req.
REQ-010 Port result_valid, input, 1 bit: payout is valid this cycle.
REQ-011 Port payout, input, SCORE_W bits: winnings to add to credit.
REQ-012 Port credit, output, SCORE_W bits: current registered credit.
REQ-013 Port bet_amt, output, BET_W bits: registered amount of the bet in flight.
REQ-014 Port spin_req, output, 1 bit: spin request, held until acknowledged.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.
REQ-016 Port reject, output, 1 bit: one-cycle pulse when a bet is refused.

Function
REQ-017 The FSM has four states: IDLE, DEBIT, SPIN_REQ and WAIT_RESULT.
REQ-018 IDLE with bet_go=1:
- requested amount is req = max_sel ? MAX_BET : 1.
- if credit >= req: latch bet_amt=req and go to DEBIT.
- otherwise: pulse reject the next cycle, stay in IDLE, leave credit unchanged.
REQ-019 DEBIT takes one cycle: credit <= credit - bet_amt using two's-complement subtraction, zero-extended to SCORE_W bits; it never underflows, per REQ-018. Next state is SPIN_REQ.
REQ-020 SPIN_REQ: spin_req=1 for as long as the FSM remains in this state; on spin_ack=1, go to WAIT_RESULT, with spin_req low from the next cycle.
REQ-021 WAIT_RESULT: on result_valid=1, credit <= credit + payout, saturating at 2^SCORE_W-1 (no wrap); next state is IDLE.
REQ-022 bet_go is ignored while busy=1; it is neither queued nor rejected.
REQ-023 result_valid and spin_ack are ignored outside WAIT_RESULT and SPIN_REQ respectively.
REQ-024 Latency: bet_go to the first spin_req cycle is exactly 2 clocks; the credit debit is visible 2 clocks after bet_go.
REQ-025 A payout of 0 is legal and leaves credit at its post-debit value.
REQ-026 bet_amt holds its value until the next accepted bet.

Reset
REQ-027 When Reset=1 at a clock edge, all outputs take these values on that edge, overriding any in-progress operation in any state:
- state = IDLE
- credit = START_CREDIT
- bet_amt = 0
- spin_req = 0
- busy = 0
- reject = 0
REQ-028 A debit performed before a mid-operation reset is not refunded; credit returns to START_CREDIT.

Configuration
REQ-029 Macro BET_AUTO_CLAMP_EN, when defined: a bet with 0 < credit < req is accepted with bet_amt = credit (all-in), and reject pulses only when credit = 0.
REQ-030 When BET_AUTO_CLAMP_EN is undefined, REQ-018 applies unchanged.

Verification
REQ-031 After reset (credit=10): bet_go with max_sel=1 -> bet_amt=5, credit=5 two cycles later, spin_req=1.
REQ-032 credit=10: bet_go with max_sel=0, spin_ack after 3 cycles, result_valid with payout=20 -> credit=29, busy=0.
REQ-033 credit=3, max_sel=1: without the macro -> reject pulse, credit=3; with BET_AUTO_CLAMP_EN -> bet_amt=3, credit=0.
REQ-034 credit=2^17-3, payout=10 -> credit=2^17-1 (saturated).
REQ-035 Reset asserted in WAIT_RESULT -> next cycle credit=10, busy=0, spin_req=0; a bet_go pulsed while busy produces no effect.
